roll_scheduler: RTL and testbench

- Sequences the lab1 random-value generator through a decelerating "dice roll".
- On i_start it issues one-cycle o_step pulses to the generator at lengthening intervals, samples the generator output on each step, and ends with a settle period and o_done.
- Keeps a two-entry history of final results for display.
- Sits between the debounced start key and the generator / seven-segment path.

---
 rtl/roll_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_roll_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/roll_scheduler.sv
// Purpose : paces the random-value generator through a decelerating dice roll and keeps a two-deep result history.
// Latency : o_step/o_done are combinational off the tick counters; o_value/o_prev update the cycle after o_step/o_done.
// Backpr. : none; i_start is level-sampled every cycle and always wins (re-arms the roll, suppresses step/done).
//
// Ports:
//   i_clk, i_rst (async, active low)
//   i_start        start / restart a roll (level, sampled every cycle)
//   i_rand[W]      current generator value, sampled in the o_step cycle
//   o_step         one-cycle pulse asking the generator for a new value
//   o_value[W]     last sampled value (live roll display)
//   o_busy         roll in progress; low in the o_done cycle and in IDLE
//   o_done         one-cycle pulse when the roll has settled
//   o_prev[2W]     {previous result, most recent result}
module roll_scheduler #(
    parameter int WIDTH      = 4,
    parameter int TICK_DIV   = 50000,
    parameter int BASE_INT   = 50,
    parameter int FAST_STEPS = 6,
    parameter int SLOW_START = 200,
    parameter int GROWTH     = 100,
    parameter int NUM_STEPS  = 14,
    parameter int SETTLE_INT = 50
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_rand,
    output logic               o_step,
    output logic [WIDTH-1:0]   o_value,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_prev
);

    // Prescaler needs at least one bit even when TICK_DIV is 1.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Longest slow interval, i.e. the one used by the final step.
    localparam int MAX_SLOW = (NUM_STEPS > FAST_STEPS)
                            ? SLOW_START + (NUM_STEPS - 1 - FAST_STEPS) * GROWTH
                            : 0;

    // Reject parameter sets that would overflow the 16-bit interval
    // counter, the 5-bit step index, or give a zero-length interval.
    generate
        if (WIDTH < 1 || TICK_DIV < 1 || FAST_STEPS < 1 ||
            NUM_STEPS < FAST_STEPS || NUM_STEPS > 31 ||
            BASE_INT < 1 || BASE_INT > 65535 ||
            SETTLE_INT < 1 || SETTLE_INT > 65535 ||
            GROWTH < 0 || MAX_SLOW > 65535 ||
            (NUM_STEPS > FAST_STEPS && SLOW_START < 1)) begin : g_param_check
            $error("roll_scheduler: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [4:0]      k_q, k_d;
    logic [15:0]     interval;
    logic            tick;

    logic [WIDTH-1:0]   value_q;
    logic [2*WIDTH-1:0] prev_q;

    // Interval length in ticks for the current step index.
    always_comb begin
        if (k_q < 5'(FAST_STEPS)) begin
            interval = 16'(BASE_INT);
        end else begin
            interval = 16'(SLOW_START + (int'(k_q) - FAST_STEPS) * GROWTH);
        end
    end

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        o_step  = 1'b0;
        o_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                cnt_d   = '0;
                k_d     = '0;
            end
            ST_RUN: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    if (cnt_q == interval - 16'd1) begin
                        o_step = 1'b1;
                        cnt_d  = '0;
                        if (k_q == 5'(NUM_STEPS - 1)) begin
                            state_d = ST_SETTLE;
                            k_d     = '0;
                        end else begin
                            k_d = k_q + 5'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_SETTLE: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    if (cnt_q == 16'(SETTLE_INT - 1)) begin
                        o_done  = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        presc_d = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
                cnt_d   = '0;
                k_d     = '0;
            end
        endcase

        // A start re-arms from step 0 and masks any step/done that the
        // counters would otherwise have produced this cycle.
        if (i_start) begin
            state_d = ST_RUN;
            presc_d = '0;
            cnt_d   = '0;
            k_d     = '0;
            o_step  = 1'b0;
            o_done  = 1'b0;
        end

        // Busy falls together with the done pulse.
        o_busy = (state_q != ST_IDLE) && !o_done;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            value_q <= '0;
            prev_q  <= '0;
        end else begin
            if (o_step) begin
                value_q <= i_rand;
            end
            if (o_done) begin
                prev_q <= {prev_q[WIDTH-1:0], value_q};
            end
        end
    end

    assign o_value = value_q;
    assign o_prev  = prev_q;

endmodule

// File: tb/tb_roll_scheduler.sv
module tb_roll_scheduler;

    logic       i_clk;
    logic       i_rst;
    logic       i_start;
    logic [3:0] i_rand;
    logic       o_step;
    logic [3:0] o_value;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_prev;

    int n_vec;
    int n_bad;

    roll_scheduler #(
        .WIDTH      (4),
        .TICK_DIV   (1),
        .BASE_INT   (2),
        .FAST_STEPS (2),
        .SLOW_START (4),
        .GROWTH     (1),
        .NUM_STEPS  (4),
        .SETTLE_INT (3)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_rand  (i_rand),
        .o_step  (o_step),
        .o_value (o_value),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_prev  (o_prev)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       start;
        logic [3:0] rnd;
        logic       step;
        logic       done;
        logic       busy;
        logic [3:0] value;
        logic [7:0] prev;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int n, logic start, logic [3:0] rnd, logic step,
                                logic done, logic busy, logic [3:0] value, logic [7:0] prev);
        vec_t v;
        v.start = start; v.rnd = rnd; v.step = step; v.done = done;
        v.busy = busy; v.value = value; v.prev = prev;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    function automatic logic [63:0] rng(int lo, int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bit_at(int i);
        logic [63:0] m;
        m = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs n cycles (cycle 0 starts at the next rising edge); i_start is
    // high for cycles s0..s1 and for cycle r. Outputs are captured on the
    // falling edge of each cycle.
    task automatic run_trace(input int n, input int s0, input int s1, input int r,
                             input logic [3:0] rnd,
                             output logic [63:0] step_m, output logic [63:0] done_m,
                             output logic [63:0] busy_m);
        step_m = '0;
        done_m = '0;
        busy_m = '0;
        for (int c = 0; c < n; c++) begin
            @(posedge i_clk);
            #1;
            i_start = ((c >= s0) && (c <= s1)) || (c == r);
            i_rand  = rnd;
            @(negedge i_clk);
            step_m[c] = o_step;
            done_m[c] = o_done;
            busy_m[c] = o_busy;
        end
        i_start = 1'b0;
    endtask

    logic [63:0] sm, dm, bm;
    logic [63:0] exp_step_basic;

    initial begin
        n_vec = 0;
        n_bad = 0;
        i_rst = 1'b0;
        i_start = 1'b0;
        i_rand = 4'h0;

        exp_step_basic = bit_at(2) | bit_at(4) | bit_at(8) | bit_at(13);

        // Idle after reset, then a single roll with i_rand=7 from cycle 0.
        add(4, 0, 7, 0, 0, 0, 4'h0, 8'h00);
        add(1, 1, 7, 0, 0, 0, 4'h0, 8'h00);   // c0 start
        add(1, 0, 7, 0, 0, 1, 4'h0, 8'h00);   // c1
        add(1, 0, 7, 1, 0, 1, 4'h0, 8'h00);   // c2 step0
        add(1, 0, 7, 0, 0, 1, 4'h7, 8'h00);   // c3
        add(1, 0, 7, 1, 0, 1, 4'h7, 8'h00);   // c4 step1
        add(3, 0, 7, 0, 0, 1, 4'h7, 8'h00);   // c5-7
        add(1, 0, 7, 1, 0, 1, 4'h7, 8'h00);   // c8 step2
        add(4, 0, 7, 0, 0, 1, 4'h7, 8'h00);   // c9-12
        add(1, 0, 7, 1, 0, 1, 4'h7, 8'h00);   // c13 step3
        add(2, 0, 7, 0, 0, 1, 4'h7, 8'h00);   // c14-15 settle
        add(1, 0, 7, 0, 1, 0, 4'h7, 8'h00);   // c16 done
        add(2, 0, 7, 0, 0, 0, 4'h7, 8'h07);   // c17-18

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_outputs", {51'd0, o_step, o_done, o_busy, o_value, o_prev}, 64'd0);
        i_rst = 1'b1;

        foreach (vecs[i]) begin
            @(posedge i_clk);
            #1;
            i_start = vecs[i].start;
            i_rand  = vecs[i].rnd;
            @(negedge i_clk);
            n_vec++;
            if (o_step !== vecs[i].step || o_done !== vecs[i].done || o_busy !== vecs[i].busy ||
                o_value !== vecs[i].value || o_prev !== vecs[i].prev) begin
                n_bad++;
                $display("FAIL vec%0d: got step=%b done=%b busy=%b value=%h prev=%h expected step=%b done=%b busy=%b value=%h prev=%h",
                         i, o_step, o_done, o_busy, o_value, o_prev,
                         vecs[i].step, vecs[i].done, vecs[i].busy, vecs[i].value, vecs[i].prev);
            end
        end

        // Two back-to-back complete rolls build the history.
        run_trace(20, 0, 0, -1, 4'h3, sm, dm, bm);
        chk("roll3_steps", sm, exp_step_basic);
        chk("roll3_done", dm, bit_at(16));
        chk("roll3_prev", {56'd0, o_prev}, 64'h73);
        run_trace(20, 0, 0, -1, 4'h9, sm, dm, bm);
        chk("roll9_done", dm, bit_at(16));
        chk("roll9_busy", bm, rng(1, 15));
        chk("roll9_prev", {56'd0, o_prev}, 64'h39);

        // Restart exactly when step 2 would fire.
        run_trace(30, 0, 0, 8, 4'h5, sm, dm, bm);
        chk("restart_steps", sm, bit_at(2) | bit_at(4) | bit_at(10) | bit_at(12) | bit_at(16) | bit_at(21));
        chk("restart_done", dm, bit_at(24));
        chk("restart_busy", bm, rng(1, 23));
        chk("restart_prev", {56'd0, o_prev}, 64'h95);
        chk("restart_excl", sm & dm, 64'd0);

        // Start held high for cycles 0-4.
        run_trace(25, 0, 4, -1, 4'h2, sm, dm, bm);
        chk("held_steps", sm, bit_at(6) | bit_at(8) | bit_at(12) | bit_at(17));
        chk("held_done", dm, bit_at(20));
        chk("held_busy", bm, rng(1, 19));
        chk("held_prev", {56'd0, o_prev}, 64'h52);

        // Asynchronous reset in the middle of SETTLE.
        @(posedge i_clk);
        #1;
        i_start = 1'b1;
        i_rand  = 4'hA;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (13) @(posedge i_clk);
        #3;
        chk("pre_rst_state", {59'd0, o_busy, o_value}, {59'd0, 1'b1, 4'hA});
        i_rst = 1'b0;
        #1;
        chk("async_rst_out", {51'd0, o_step, o_done, o_busy, o_value, o_prev}, 64'd0);
        dm = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            dm[c] = o_done;
        end
        chk("rst_no_done", dm, 64'd0);
        i_rst = 1'b1;

        run_trace(20, 0, 0, -1, 4'h7, sm, dm, bm);
        chk("post_rst_steps", sm, exp_step_basic);
        chk("post_rst_done", dm, bit_at(16));
        chk("post_rst_busy", bm, rng(1, 15));
        chk("post_rst_val", {56'd0, o_prev}, 64'h07);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
